// File: rtl/pfp_dbg_pkg.sv
// +--------------------------------------------------------------------------+
// | pfp_dbg_pkg : shared types and report-word layout for the deadlock debug |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package pfp_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int REPORT_W = 64;
  localparam int TS_LSB   = 32;
  localparam int IDX_LSB  = 24;
  localparam int RPT_LSB  = 16;
  localparam int MASK_LSB = 0;
  localparam int TS_W     = 32;
  localparam int IDX_W    = 8;
  localparam int RPT_W    = 8;
  localparam int MASK_W   = 16;

endpackage

`default_nettype wire

// File: rtl/pfp_block_timeout.sv
// +--------------------------------------------------------------------------+
// | pfp_block_timeout : per-monitor consecutive-blocked-cycle qualifier      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pfp_block_timeout #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_block,
  input  logic i_clear,
  output logic o_fire
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == c_LAST);
  assign o_fire    = i_block & w_at_last;

  // Saturates at TIMEOUT-1 so a monitor that stays blocked keeps firing.
  always_ff @(posedge clock) begin
    if (reset || i_clear || !i_block) begin
      r_cnt <= '0;
    end else if (!w_at_last) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/photon_fifo_packetizer_hls_deadlock_reporter.sv
// +--------------------------------------------------------------------------+
// | photon_fifo_packetizer_hls_deadlock_reporter : qualifies HLS block flags |
// | and emits one timestamped 64-bit AXI-Stream report word. Rev 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

module photon_fifo_packetizer_hls_deadlock_reporter
  import pfp_dbg_pkg::*;
#(
  parameter int NUM_MON = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_MON-1:0]  i_block_in,
  input  logic                i_clear,
  output logic [REPORT_W-1:0] o_m_axis_tdata,
  output logic                o_m_axis_tvalid,
  input  logic                i_m_axis_tready,
  output logic                o_m_axis_tlast,
  output logic                o_deadlock,
  output logic [NUM_MON-1:0]  o_deadlock_mask
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [TS_W-1:0]     r_ts;
  logic [RPT_W-1:0]    r_rpt_cnt;
  logic [RPT_W-1:0]    w_rpt_nxt;
  logic [REPORT_W-1:0] r_tdata;
  logic                r_deadlock;
  logic [NUM_MON-1:0]  r_mask;
  logic [NUM_MON-1:0]  w_fire;
  logic [MASK_W-1:0]   w_fire_ext;
  logic [IDX_W-1:0]    w_idx;
  logic [REPORT_W-1:0] w_report;
  logic                w_any_fire;
  logic                w_clear_eff;
  logic                w_capture;

  // A pending report must not be disturbed, so clear only acts outside SEND.
  assign w_clear_eff = i_clear && (r_state != ST_SEND);
  assign w_any_fire  = |w_fire;
  assign w_capture   = (r_state == ST_IDLE) && !i_clear && w_any_fire;
  assign w_rpt_nxt   = r_rpt_cnt + RPT_W'(1);

  generate
    for (genvar gi = 0; gi < NUM_MON; gi++) begin : g_mon
      pfp_block_timeout #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
      ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .i_block (i_block_in[gi]),
        .i_clear (w_clear_eff),
        .o_fire  (w_fire[gi])
      );
    end
  endgenerate

  // Lowest-numbered firing monitor wins the index field.
  always_comb begin
    w_fire_ext = '0;
    w_fire_ext[NUM_MON-1:0] = w_fire;
    w_idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (w_fire[i]) begin
        w_idx = IDX_W'(i);
      end
    end
    w_report = '0;
    w_report[TS_LSB   +: TS_W]   = r_ts;
    w_report[IDX_LSB  +: IDX_W]  = w_idx;
    w_report[RPT_LSB  +: RPT_W]  = w_rpt_nxt;
    w_report[MASK_LSB +: MASK_W] = w_fire_ext;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_capture)       w_state_nxt = ST_SEND;
      ST_SEND: if (i_m_axis_tready) w_state_nxt = ST_HOLD;
      ST_HOLD: if (i_clear)         w_state_nxt = ST_IDLE;
      default:                      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ts       <= '0;
      r_rpt_cnt  <= '0;
      r_tdata    <= '0;
      r_deadlock <= 1'b0;
      r_mask     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ts    <= r_ts + TS_W'(1);
      r_mask  <= w_clear_eff ? '0 : (r_mask | w_fire);
      if (w_capture) begin
        r_tdata    <= w_report;
        r_rpt_cnt  <= w_rpt_nxt;
        r_deadlock <= 1'b1;
      end else if (w_clear_eff) begin
        r_deadlock <= 1'b0;
      end
    end
  end

  assign o_m_axis_tdata  = r_tdata;
  assign o_m_axis_tvalid = (r_state == ST_SEND);
  assign o_m_axis_tlast  = 1'b1;
  assign o_deadlock      = r_deadlock;
  assign o_deadlock_mask = r_mask;

endmodule

`default_nettype wire

// File: tb/tb_photon_fifo_packetizer_hls_deadlock_reporter.sv
// +--------------------------------------------------------------------------+
// | tb_photon_fifo_packetizer_hls_deadlock_reporter : directed bench, TIMEOUT=8 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_photon_fifo_packetizer_hls_deadlock_reporter;

  localparam int NM = 4;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NM-1:0] block_in = '0;
  logic          clear = 1'b0;
  logic          tready = 1'b1;
  logic [63:0]   tdata;
  logic          tvalid;
  logic          tlast;
  logic          deadlock;
  logic [NM-1:0] dmask;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] tb_ts;

  always #5 clock = ~clock;

  // Reference cycle counter, same semantics as the design's timestamp.
  always @(posedge clock) begin
    if (reset) tb_ts <= '0;
    else       tb_ts <= tb_ts + 32'd1;
  end

  photon_fifo_packetizer_hls_deadlock_reporter #(
    .NUM_MON (NM),
    .TIMEOUT (TO),
    .CNT_W   (16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .i_block_in      (block_in),
    .i_clear         (clear),
    .o_m_axis_tdata  (tdata),
    .o_m_axis_tvalid (tvalid),
    .i_m_axis_tready (tready),
    .o_m_axis_tlast  (tlast),
    .o_deadlock      (deadlock),
    .o_deadlock_mask (dmask)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] rpt(input logic [31:0] ts, input logic [7:0] idx,
                                      input logic [7:0] cnt, input logic [15:0] vec);
    return {ts, idx, cnt, vec};
  endfunction

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  typedef struct {
    int mon;
    int len;
    bit fire;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [7:0]  exp_rpt;
    logic [31:0] ts0;
    logic [63:0] got;
    logic [63:0] exp_word;
    int          nvalid;
    bit          anyv;

    vecs[0] = '{mon: 0, len: 8,  fire: 1'b1};
    vecs[1] = '{mon: 1, len: 7,  fire: 1'b0};
    vecs[2] = '{mon: 3, len: 8,  fire: 1'b1};
    vecs[3] = '{mon: 2, len: 20, fire: 1'b1};
    vecs[4] = '{mon: 1, len: 1,  fire: 1'b0};

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", tdata, 64'd0);
    chk("rst_deadlock", 64'(deadlock), 64'd0);
    chk("rst_mask", 64'(dmask), 64'd0);
    chk("rst_ts", 64'(dut.r_ts), 64'd0);
    chk("tlast", 64'(tlast), 64'd1);
    reset = 1'b0;

    // Test 1: block_in[2] from ts=10
    for (int i = 0; i < 50 && tb_ts != 32'd10; i++) @(negedge clock);
    chk("t1_sync", 64'(tb_ts), 64'd10);
    block_in = 4'b0100;
    anyv = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clock);
      anyv |= tvalid;
    end
    chk("t1_early_valid", 64'(anyv), 64'd0);
    @(negedge clock);
    chk("t1_valid", 64'(tvalid), 64'd1);
    chk("t1_tdata", tdata, rpt(32'd17, 8'd2, 8'd1, 16'h0004));
    chk("t1_deadlock", 64'(deadlock), 64'd1);
    exp_rpt = 8'd1;
    block_in = '0;
    @(negedge clock);
    chk("t1_handshake", 64'(tvalid), 64'd0);
    chk("t1_mask", 64'(dmask), 64'h4);
    pulse_clear();
    chk("t1_clr_deadlock", 64'(deadlock), 64'd0);

    // Test 2: 7 high, 1 low, 7 high never qualifies
    anyv = 1'b0;
    for (int k = 0; k < 17; k++) begin
      block_in = (k < 7 || (k >= 8 && k < 15)) ? 4'b0010 : 4'b0000;
      @(negedge clock);
      anyv |= tvalid;
    end
    chk("t2_no_valid", 64'(anyv), 64'd0);
    chk("t2_deadlock", 64'(deadlock), 64'd0);
    chk("t2_mask", 64'(dmask), 64'd0);

    // Table-driven single-monitor pulses, tready held high
    foreach (vecs[v]) begin
      nvalid = 0;
      got = '0;
      ts0 = tb_ts;
      for (int k = 0; k < vecs[v].len + 4; k++) begin
        block_in = (k < vecs[v].len) ? NM'(1 << vecs[v].mon) : '0;
        @(negedge clock);
        if (tvalid) begin
          nvalid++;
          got = tdata;
        end
      end
      chk($sformatf("vec%0d_nreports", v), 64'(nvalid), vecs[v].fire ? 64'd1 : 64'd0);
      chk($sformatf("vec%0d_deadlock", v), 64'(deadlock), 64'(vecs[v].fire));
      chk($sformatf("vec%0d_mask", v), 64'(dmask), vecs[v].fire ? 64'(1 << vecs[v].mon) : 64'd0);
      if (vecs[v].fire) begin
        exp_rpt = exp_rpt + 8'd1;
        chk($sformatf("vec%0d_tdata", v), got,
            rpt(ts0 + 32'd7, 8'(vecs[v].mon), exp_rpt, 16'(1 << vecs[v].mon)));
      end
      pulse_clear();
      chk($sformatf("vec%0d_clr", v), 64'({deadlock, dmask}), 64'd0);
    end

    // Test 3: simultaneous monitors 0 and 3, back-pressure for 20 cycles
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    tready = 1'b0;
    block_in = 4'b1001;
    ts0 = tb_ts;
    for (int i = 0; i < 12 && !tvalid; i++) @(negedge clock);
    chk("t3_valid", 64'(tvalid), 64'd1);
    exp_word = rpt(ts0 + 32'd7, 8'd0, 8'd1, 16'h0009);
    chk("t3_tdata", tdata, exp_word);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk($sformatf("t3_stable%0d", i), {tdata[62:0], tvalid}, {exp_word[62:0], 1'b1});
    end
    tready = 1'b1;
    @(negedge clock);
    chk("t3_handshake", 64'(tvalid), 64'd0);

    // Test 4: monitor 1 times out in HOLD, then clear re-arms
    block_in = 4'b0010;
    tready = 1'b0;
    anyv = 1'b0;
    for (int j = 0; j < 9; j++) begin
      @(negedge clock);
      anyv |= tvalid;
    end
    chk("t4_hold_no_report", 64'(anyv), 64'd0);
    chk("t4_hold_mask", 64'(dmask), 64'hB);
    ts0 = tb_ts;
    pulse_clear();
    chk("t4_clr", 64'({deadlock, dmask}), 64'd0);
    anyv = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clock);
      anyv |= tvalid;
    end
    chk("t4_refire_early", 64'(anyv), 64'd0);
    @(negedge clock);
    chk("t4_refire_valid", 64'(tvalid), 64'd1);
    exp_word = rpt(ts0 + 32'd8, 8'd1, 8'd2, 16'h0002);
    chk("t4_refire_tdata", tdata, exp_word);

    // Test 5: clear during SEND is ignored
    pulse_clear();
    chk("t5_valid", 64'(tvalid), 64'd1);
    chk("t5_deadlock", 64'(deadlock), 64'd1);
    chk("t5_tdata", tdata, exp_word);

    // Test 6: reset mid-SEND drops the report
    reset = 1'b1;
    block_in = '0;
    @(negedge clock);
    chk("t6_valid", 64'(tvalid), 64'd0);
    chk("t6_deadlock", 64'(deadlock), 64'd0);
    chk("t6_ts", 64'(dut.r_ts), 64'd0);
    reset = 1'b0;
    tready = 1'b1;
    @(negedge clock);

    // Timestamp wrap carried in the report
    force dut.r_ts = 32'hFFFF_FFFA;
    block_in = 4'b0100;
    #1 release dut.r_ts;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clock);
      if (j == 6) chk("wrap_ts_zero", 64'(dut.r_ts), 64'd0);
    end
    chk("wrap_valid", 64'(tvalid), 64'd1);
    chk("wrap_tdata", tdata, rpt(32'd1, 8'd2, 8'd1, 16'h0004));
    block_in = '0;
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
